simple_c_pipe: RTL
==================

Name: simple_c_pipe

Overview:
- Parametrised, clocked successor to the 3-gate `simple_c` cell: D = (A & B) | ~C and E = ~C, evaluated over WIDTH independent lanes.
- Each gate's propagation delay is a configurable number of clock cycles, implemented as a transport-delay shift register.
- Reconvergent-path hazards (unequal AND vs NOT delay) therefore appear cycle-accurately at the outputs.
- Used as a synthesizable timing-behaviour model and glitch-statistics source in gate-level experiments.

Parameters:
- WIDTH, 4, number of independent lanes.
- AND_DLY, 3, AND-gate delay in cycles (≥1).
- NOT_DLY, 1, NOT-gate delay in cycles (≥1).
- OR_DLY, 2, OR-gate delay in cycles (≥1).
- CNT_W, 8, width of the toggle counter.
- HZ_WIN, 4, hazard window in cycles (≥1; used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  capture strobe for a/b/c.
- a  in  WIDTH  lane input A.
- b  in  WIDTH  lane input B.
- c  in  WIDTH  lane input C.
- d_out  out  WIDTH  lane output D.
- e_out  out  WIDTH  lane output E.
- out_valid  out  1  pipeline filled since reset.
- d_toggle_cnt  out  CNT_W  saturating count of cycles in which any d_out bit changed.
- hazard  out  WIDTH  per-lane glitch pulse (optional feature).

Behaviour:
- Synchronous reset (rst=1 at an edge) loads steady state for a=b=c=0:
  - input register = 0; AND chain all 0; NOT chain all 1; OR chain all 1.
  - d_out = all 1; e_out = all 1; d_toggle_cnt = 0; out_valid = 0; hazard = 0; fill counter = 0.
- Reset asserted mid-operation discards all in-flight values and returns to this same state at that edge.
- Input register: captures a, b, c at an edge where in_valid=1, otherwise holds. The delay chains shift every cycle regardless of in_valid.
- Capture at edge k produces:
  - AND chain: AND_DLY stages fed by a_r & b_r. Output w1_d reflects the capture after edge k+AND_DLY.
  - NOT chain: NOT_DLY stages fed by ~c_r. Output e_d reflects the capture after edge k+NOT_DLY. e_out = e_d.
  - OR chain: OR_DLY stages fed by w1_d | e_d. d_out = last stage. The path via c settles at k+NOT_DLY+OR_DLY; the path via a/b settles at k+AND_DLY+OR_DLY.
- Latency is transport, not inertial: pulses of any width, including 1 cycle, propagate unfiltered.
- out_valid:
  - Fill counter increments each non-reset edge, saturating at L = max(AND_DLY, NOT_DLY) + OR_DLY.
  - out_valid = 1 once the counter equals L; it stays 1 until the next reset.
- d_toggle_cnt:
  - Compares d_out with its value one cycle earlier; increments by 1 per cycle in which any lane differs, regardless of how many lanes change.
  - Saturates at 2^CNT_W−1 (no wrap).
  - The first comparison after reset uses the reset value (all 1).
- Lanes are fully independent; there is no cross-lane logic except the shared toggle counter and out_valid.

Optional Feature:
- Macro: SIMPLE_C_HAZARD_DET_EN.
- Defined:
  - Per-lane "cycles since last d_out change" counter, saturating at HZ_WIN, reset to HZ_WIN.
  - When d_out[i] changes and the counter is < HZ_WIN, hazard[i] pulses 1 for exactly that cycle. Counter clears to 0 on every change.
  - Net effect: a change back within HZ_WIN cycles of the previous change flags a glitch.
- Not defined: hazard driven constant 0; counters not synthesized; port still present.

Test Plan:
- Reset, hold a=b=c=0 → d_out=4'hF and e_out=4'hF immediately after the reset edge; out_valid rises on the 5th edge after reset release; d_toggle_cnt=0.
- Defaults; at edge k capture a=b=c=4'hF →
  - e_out=0 after edge k+1.
  - d_out=0 after edges k+3 and k+4; d_out=4'hF from edge k+5 (2-cycle glitch).
  - d_toggle_cnt=2.
  - With SIMPLE_C_HAZARD_DET_EN: hazard=4'hF for one cycle after edge k+5 only.
- Lane independence: capture a=4'b0001, b=4'b0001, c=4'b0011 from reset → lane0 glitches low 2 cycles; lane1 falls to 0 and stays; lanes 2/3 unchanged at 1; e_out=4'b1100.
- in_valid=0 while inputs toggle every cycle → outputs remain at the last captured values; d_toggle_cnt unchanged.
- Assert rst during the glitch window (edge k+4) → d_out=e_out=4'hF, d_toggle_cnt=0, out_valid=0 on that edge; no hazard pulse.
- CNT_W=2, generate 5 glitch pairs → d_toggle_cnt saturates at 3.

Source files
------------

// File: rtl/simple_c_pipe.sv
// Clocked, multi-lane model of the simple_c cell: d = (a & b) | ~c, e = ~c, with each gate's
// delay as a transport shift register. Optional per-lane glitch detector: SIMPLE_C_HAZARD_DET_EN.
module simple_c_pipe #(
  parameter int WIDTH   = 4,
  parameter int AND_DLY = 3,
  parameter int NOT_DLY = 1,
  parameter int OR_DLY  = 2,
  parameter int CNT_W   = 8,
  parameter int HZ_WIN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] e_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] d_toggle_cnt,
  output logic [WIDTH-1:0] hazard
);

  localparam int PATH_MAX = (AND_DLY > NOT_DLY) ? AND_DLY : NOT_DLY;
  localparam int FILL_L   = PATH_MAX + OR_DLY;
  localparam int FILL_W   = $clog2(FILL_L + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_L);
  localparam logic [CNT_W-1:0]  TOG_MAX  = {CNT_W{1'b1}};
  // A misconfigured instance (any delay or window below one) never reports a filled pipeline.
  localparam bit PARAMS_OK = (AND_DLY >= 1) && (NOT_DLY >= 1) && (OR_DLY >= 1) && (HZ_WIN >= 1);

  // in_valid is a one-cycle capture strobe with no backpressure: a/b/c are taken at any edge
  // where in_valid=1, while the gate chains below advance every cycle regardless.
  logic [WIDTH-1:0] a_r, b_r, c_r;
  logic [WIDTH-1:0] and_sr [AND_DLY];
  logic [WIDTH-1:0] not_sr [NOT_DLY];
  logic [WIDTH-1:0] or_sr  [OR_DLY];
  logic [WIDTH-1:0] w1_d, e_d, d_prev, d_diff;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  tog_cnt;

  assign w1_d   = and_sr[AND_DLY-1];
  assign e_d    = not_sr[NOT_DLY-1];
  assign d_out  = or_sr[OR_DLY-1];
  assign e_out  = e_d;
  assign d_diff = d_out ^ d_prev;

  assign out_valid    = PARAMS_OK && (fill == FILL_MAX);
  assign d_toggle_cnt = tog_cnt;

  // Reset loads the settled state of a=b=c=0 so no spurious edges follow reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      for (int i = 0; i < AND_DLY; i++) and_sr[i] <= '0;
      for (int i = 0; i < NOT_DLY; i++) not_sr[i] <= '1;
      for (int i = 0; i < OR_DLY; i++)  or_sr[i]  <= '1;
    end else begin
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
        c_r <= c;
      end
      and_sr[0] <= a_r & b_r;
      for (int i = 1; i < AND_DLY; i++) and_sr[i] <= and_sr[i-1];
      not_sr[0] <= ~c_r;
      for (int i = 1; i < NOT_DLY; i++) not_sr[i] <= not_sr[i-1];
      or_sr[0] <= w1_d | e_d;
      for (int i = 1; i < OR_DLY; i++)  or_sr[i]  <= or_sr[i-1];
    end
  end

  // d_prev holds d_out from one cycle earlier; its reset value makes the first compare against all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev  <= '1;
      fill    <= '0;
      tog_cnt <= '0;
    end else begin
      d_prev <= d_out;
      if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
      if ((|d_diff) && (tog_cnt != TOG_MAX)) tog_cnt <= tog_cnt + CNT_W'(1);
    end
  end

`ifdef SIMPLE_C_HAZARD_DET_EN
  localparam int HZ_CW = $clog2(HZ_WIN + 1);
  localparam logic [HZ_CW-1:0] HZ_MAX = HZ_CW'(HZ_WIN);

  logic [HZ_CW-1:0] hz_cnt [WIDTH];

  // Cycles since the lane's last d_out change, parked at HZ_MAX when quiet.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst)                      hz_cnt[i] <= HZ_MAX;
      else if (d_diff[i])           hz_cnt[i] <= '0;
      else if (hz_cnt[i] != HZ_MAX) hz_cnt[i] <= hz_cnt[i] + HZ_CW'(1);
    end
  end

  always_comb begin
    hazard = '0;
    for (int i = 0; i < WIDTH; i++) hazard[i] = d_diff[i] && (hz_cnt[i] < HZ_MAX);
  end
`else
  assign hazard = '0;
`endif

endmodule
